sva_thread_scheduler: RTL and testbench
=======================================

Name: sva_thread_scheduler

Overview:
Schedules concurrent assertion-thread instances for one SVA-derived checker FSM. Runs in the sys_clk domain and owns a pool of thread slots. On every user-clock tick it walks the live threads through an external next-state evaluator over a req/ack handshake, then spawns one new thread from the start state. It compacts retired threads out of the pool and accumulates pass/fail statistics. It sits between the gclk edge detector and the per-property next-state unit.

Parameters:
NUM_SLOTS, 4, maximum simultaneously live threads (>=1)
STATE_W, 32, width of encoded checker state (signed enum)
TIMER_WIDTH, 8, width of start-period timestamp
START_STATE, 0, state loaded into each spawned thread
CNT_W, 16, width of statistics counters

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous active-high reset
gclk_tick  in  1  one-cycle pulse per detected gclk rising edge
timer_in  in  TIMER_WIDTH  user-clock timestamp, sampled with gclk_tick
eval_req  out  1  evaluate request
eval_state  out  STATE_W  current state of the thread under evaluation
eval_period  out  TIMER_WIDTH  start period of the thread under evaluation
eval_ack  in  1  evaluator result valid
eval_next_state  in  STATE_W  next state
eval_next_active  in  1  thread survives this round
eval_verdict  in  2  00 none, 01 succ, 10 fail, 11 lazy_succ
busy  out  1  round in progress
round_done  out  1  one-cycle pulse at the end of each round
live_cnt  out  $clog2(NUM_SLOTS+1)  live threads after the last round
succ_cnt / fail_cnt / lazy_cnt  out  CNT_W  saturating verdict counters
overflow  out  1  sticky: a spawned thread was dropped because the pool was full
tick_overrun  out  1  sticky: gclk_tick arrived while busy

Behaviour:
- Reset (synchronous, sys_rst=1 at a sys_clk edge): state=IDLE. All slots invalid. live_cnt=0, all counters 0, overflow=0, tick_overrun=0, eval_req=0, busy=0, round_done=0. Reset wins over every other event, including a round in progress; the in-flight evaluation is abandoned.
- Slot storage: array of {state, period}. Valid slots are always packed in indices 0..live_cnt-1.
- FSM states: IDLE, SCAN, EVAL, DONE. busy = (state != IDLE). All outputs are registered.
- IDLE: on gclk_tick, latch timer_in into spawn_period, set rd=0, wr=0, spawning=0, and go to SCAN.
- SCAN:
  - If rd < live_cnt: load slot[rd] into eval_state/eval_period.
  - Otherwise: load {START_STATE, spawn_period} and set spawning=1.
  - Set eval_req=1 and go to EVAL.
- EVAL:
  - Hold eval_req and the eval_* outputs stable until eval_ack=1 is sampled. Ack arriving in the first EVAL cycle is legal.
  - On ack, if eval_next_active=1: write {eval_next_state, eval_period} to slot[wr] and increment wr. In-place compaction is safe because wr<=rd.
  - On ack, if eval_next_active=1, spawning=1 and wr==NUM_SLOTS: do not write, and set overflow=1.
  - On ack, increment the counter selected by eval_verdict (saturate at all-ones) and drop eval_req.
  - On ack, if spawning=0: increment rd and go to SCAN. If spawning=1: go to DONE.
- DONE: live_cnt <= wr (final value), round_done=1 for this cycle, then go to IDLE.
- Timing with zero-wait ack, tick in cycle T, N live threads:
  - Thread k is in SCAN at T+1+2k.
  - The spawn thread is in EVAL at T+2+2N.
  - round_done is high at T+3+2N.
  - busy drops at T+4+2N.
- gclk_tick while busy: ignored (no queueing) and tick_overrun=1. A tick in the same cycle as round_done is also an overrun.
- A thread that retires (eval_next_active=0) frees its slot in that round.
- A verdict with eval_next_active=1 is still counted.
- Period is carried unchanged through evaluations. Wrap-around of timer_in is the evaluator's concern.

Decomposition:
- Shared package sva_sched_pkg:
  - verdict enum (NONE, SUCC, FAIL, LAZY)
  - scheduler FSM enum
  - slot struct {state, period}
  - counter saturate function
- One natural sub-module: sva_slot_pool (packed slot array with read port rd and write port wr, plus the wr/overflow logic).
- The evaluator is external and not part of this block.

Test Plan:
- Reset, then tick with timer_in=5 and zero-wait ack, evaluator returns {1, S1, none} → eval_state=0, eval_period=5, round_done at T+3, live_cnt=1, slot0={1,5}.
- Two further ticks, evaluator returns {SEND, active, succ} for S1 and {S1, active, none} for START → live_cnt stays 2, succ_cnt increments once per round, slot order preserved.
- NUM_SLOTS=4, all threads stay active over 5 ticks → the 5th round's spawn is dropped, overflow=1, live_cnt=4.
- Evaluator inserts 3 wait cycles per ack → eval_req and eval_state stay stable for 4 cycles, result identical to the zero-wait case, round_done delayed by 3 per evaluation.
- gclk_tick pulsed while busy=1 → no extra round, tick_overrun=1. sys_rst asserted mid-EVAL → next cycle IDLE, live_cnt=0, eval_req=0.
- Force fail_cnt to all-ones, then a fail verdict → fail_cnt stays all-ones. Retiring the middle of 3 threads → the remaining threads are compacted into slots 0 and 1.

Source files
------------

// File: rtl/sva_sched_pkg.sv
// Shared definitions for the assertion-thread scheduler.
//   verdict_e      : evaluator verdict encoding (none / succ / fail / lazy_succ)
//   sched_state_e  : scheduler FSM states
//   sat_inc        : saturating increment for counters up to 64 bits wide
// The slot record {state, period} depends on module parameters, so it is
// declared inside sva_slot_pool, where those widths are known.
package sva_sched_pkg;

    typedef enum logic [1:0] {
        VERDICT_NONE = 2'b00,
        VERDICT_SUCC = 2'b01,
        VERDICT_FAIL = 2'b10,
        VERDICT_LAZY = 2'b11
    } verdict_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_EVAL,
        ST_DONE
    } sched_state_e;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] max_v;
        max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= max_v) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/sva_thread_scheduler_if.sv
// Request/acknowledge channel between the thread scheduler (master) and the
// external per-property next-state evaluator (slave).
//   eval_req / eval_state / eval_period : request and thread under evaluation
//   eval_ack / eval_next_state / eval_next_active / eval_verdict : result
interface sva_thread_scheduler_if #(
    parameter int STATE_W     = 32,
    parameter int TIMER_WIDTH = 8
);
    logic                   eval_req;
    logic [STATE_W-1:0]     eval_state;
    logic [TIMER_WIDTH-1:0] eval_period;
    logic                   eval_ack;
    logic [STATE_W-1:0]     eval_next_state;
    logic                   eval_next_active;
    logic [1:0]             eval_verdict;

    modport master (
        output eval_req, eval_state, eval_period,
        input  eval_ack, eval_next_state, eval_next_active, eval_verdict
    );

    modport slave (
        input  eval_req, eval_state, eval_period,
        output eval_ack, eval_next_state, eval_next_active, eval_verdict
    );
endinterface

// File: rtl/sva_slot_pool.sv
// Packed pool of live thread slots.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   clr_i                   : start of round, rewind the write pointer
//   rd_idx_i                : read pointer; rd_state_o/rd_period_o return slot[rd]
//   wr_en_i, wr_state_i,
//   wr_period_i             : append a surviving thread at slot[wr]
//   spawning_i              : current write belongs to the newly spawned thread
//   wr_cnt_o                : threads written so far this round
//   overflow_o              : sticky, a spawned thread found the pool full
// Survivors are rewritten in order at wr <= rd, so the pool stays packed in
// place without a separate compaction pass.
module sva_slot_pool #(
    parameter int NUM_SLOTS   = 4,
    parameter int STATE_W     = 32,
    parameter int TIMER_WIDTH = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             clr_i,
    input  logic [$clog2(NUM_SLOTS+1)-1:0]   rd_idx_i,
    output logic [STATE_W-1:0]               rd_state_o,
    output logic [TIMER_WIDTH-1:0]           rd_period_o,
    input  logic                             wr_en_i,
    input  logic [STATE_W-1:0]               wr_state_i,
    input  logic [TIMER_WIDTH-1:0]           wr_period_i,
    input  logic                             spawning_i,
    output logic [$clog2(NUM_SLOTS+1)-1:0]   wr_cnt_o,
    output logic                             overflow_o
);
    localparam int CIW = $clog2(NUM_SLOTS + 1);

    typedef struct packed {
        logic [STATE_W-1:0]     state;
        logic [TIMER_WIDTH-1:0] period;
    } slot_t;

    slot_t          slots_q [NUM_SLOTS];
    slot_t          slots_d [NUM_SLOTS];
    logic [CIW-1:0] wr_q, wr_d;
    logic           ovf_q, ovf_d;
    logic           full;
    slot_t          rd_slot;

    always_comb begin
        slots_d = slots_q;
        wr_d    = wr_q;
        ovf_d   = ovf_q;
        full    = (wr_q == CIW'(NUM_SLOTS));
        if (clr_i) begin
            wr_d = '0;
        end else if (wr_en_i) begin
            if (!full) begin
                for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                    if (wr_q == CIW'(i)) begin
                        slots_d[i] = '{state: wr_state_i, period: wr_period_i};
                    end
                end
                wr_d = wr_q + CIW'(1);
            end else if (spawning_i) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_comb begin
        rd_slot = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (rd_idx_i == CIW'(i)) begin
                rd_slot = slots_q[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            ovf_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            wr_q    <= wr_d;
            ovf_q   <= ovf_d;
            slots_q <= slots_d;
        end
    end

    assign rd_state_o  = rd_slot.state;
    assign rd_period_o = rd_slot.period;
    assign wr_cnt_o    = wr_q;
    assign overflow_o  = ovf_q;
endmodule

// File: rtl/sva_thread_scheduler.sv
// Schedules concurrent assertion-thread instances for one SVA checker FSM.
// Each gclk_tick starts a round: every live thread is sent through the
// external evaluator in slot order, then one new thread is spawned from
// START_STATE; retired threads drop out of the pool as the round proceeds.
//   sys_clk, sys_rst        : clock, synchronous active-high reset
//   gclk_tick, timer_in     : round trigger and its user-clock timestamp
//   ev (master)             : evaluator request/acknowledge channel
//   busy, round_done        : round in progress / end-of-round pulse
//   live_cnt                : live threads after the last round
//   succ/fail/lazy_cnt      : saturating verdict counters
//   overflow, tick_overrun  : sticky error flags
module sva_thread_scheduler
    import sva_sched_pkg::*;
#(
    parameter int NUM_SLOTS   = 4,
    parameter int STATE_W     = 32,
    parameter int TIMER_WIDTH = 8,
    parameter int START_STATE = 0,
    parameter int CNT_W       = 16
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst,
    input  logic                           gclk_tick,
    input  logic [TIMER_WIDTH-1:0]         timer_in,
    sva_thread_scheduler_if.master         ev,
    output logic                           busy,
    output logic                           round_done,
    output logic [$clog2(NUM_SLOTS+1)-1:0] live_cnt,
    output logic [CNT_W-1:0]               succ_cnt,
    output logic [CNT_W-1:0]               fail_cnt,
    output logic [CNT_W-1:0]               lazy_cnt,
    output logic                           overflow,
    output logic                           tick_overrun
);
    localparam int LW = $clog2(NUM_SLOTS + 1);

    sched_state_e           state_q, state_d;
    logic [LW-1:0]          rd_q, rd_d;
    logic [LW-1:0]          live_q, live_d;
    logic [TIMER_WIDTH-1:0] spawn_period_q, spawn_period_d;
    logic                   spawning_q, spawning_d;
    logic                   eval_req_q, eval_req_d;
    logic [STATE_W-1:0]     eval_state_q, eval_state_d;
    logic [TIMER_WIDTH-1:0] eval_period_q, eval_period_d;
    logic                   busy_q, busy_d;
    logic                   round_done_q, round_done_d;
    logic                   overrun_q, overrun_d;
    logic [CNT_W-1:0]       succ_q, succ_d, fail_q, fail_d, lazy_q, lazy_d;

    logic                   pool_clr, pool_wr_en;
    logic [STATE_W-1:0]     pool_rd_state;
    logic [TIMER_WIDTH-1:0] pool_rd_period;
    logic [LW-1:0]          pool_wr_cnt;

    sva_slot_pool #(
        .NUM_SLOTS   (NUM_SLOTS),
        .STATE_W     (STATE_W),
        .TIMER_WIDTH (TIMER_WIDTH)
    ) u_pool (
        .clk_i       (sys_clk),
        .rst_i       (sys_rst),
        .clr_i       (pool_clr),
        .rd_idx_i    (rd_q),
        .rd_state_o  (pool_rd_state),
        .rd_period_o (pool_rd_period),
        .wr_en_i     (pool_wr_en),
        .wr_state_i  (ev.eval_next_state),
        .wr_period_i (eval_period_q),
        .spawning_i  (spawning_q),
        .wr_cnt_o    (pool_wr_cnt),
        .overflow_o  (overflow)
    );

    always_comb begin
        state_d        = state_q;
        rd_d           = rd_q;
        live_d         = live_q;
        spawn_period_d = spawn_period_q;
        spawning_d     = spawning_q;
        eval_req_d     = eval_req_q;
        eval_state_d   = eval_state_q;
        eval_period_d  = eval_period_q;
        round_done_d   = 1'b0;
        succ_d         = succ_q;
        fail_d         = fail_q;
        lazy_d         = lazy_q;
        pool_clr       = 1'b0;
        pool_wr_en     = 1'b0;
        // A tick is only accepted in IDLE; anywhere else, DONE included, it is lost.
        overrun_d      = overrun_q | (gclk_tick && (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (gclk_tick) begin
                    spawn_period_d = timer_in;
                    rd_d           = '0;
                    spawning_d     = 1'b0;
                    pool_clr       = 1'b1;
                    state_d        = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (rd_q < live_q) begin
                    eval_state_d  = pool_rd_state;
                    eval_period_d = pool_rd_period;
                end else begin
                    eval_state_d  = STATE_W'(START_STATE);
                    eval_period_d = spawn_period_q;
                    spawning_d    = 1'b1;
                end
                eval_req_d = 1'b1;
                state_d    = ST_EVAL;
            end
            ST_EVAL: begin
                if (ev.eval_ack) begin
                    pool_wr_en = ev.eval_next_active;
                    case (verdict_e'(ev.eval_verdict))
                        VERDICT_SUCC: succ_d = CNT_W'(sat_inc(64'(succ_q), CNT_W));
                        VERDICT_FAIL: fail_d = CNT_W'(sat_inc(64'(fail_q), CNT_W));
                        VERDICT_LAZY: lazy_d = CNT_W'(sat_inc(64'(lazy_q), CNT_W));
                        default:      ;
                    endcase
                    eval_req_d = 1'b0;
                    if (spawning_q) begin
                        round_done_d = 1'b1;
                        state_d      = ST_DONE;
                    end else begin
                        rd_d    = rd_q + LW'(1);
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_DONE: begin
                live_d  = pool_wr_cnt;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q        <= ST_IDLE;
            rd_q           <= '0;
            live_q         <= '0;
            spawn_period_q <= '0;
            spawning_q     <= 1'b0;
            eval_req_q     <= 1'b0;
            eval_state_q   <= '0;
            eval_period_q  <= '0;
            busy_q         <= 1'b0;
            round_done_q   <= 1'b0;
            overrun_q      <= 1'b0;
            succ_q         <= '0;
            fail_q         <= '0;
            lazy_q         <= '0;
        end else begin
            state_q        <= state_d;
            rd_q           <= rd_d;
            live_q         <= live_d;
            spawn_period_q <= spawn_period_d;
            spawning_q     <= spawning_d;
            eval_req_q     <= eval_req_d;
            eval_state_q   <= eval_state_d;
            eval_period_q  <= eval_period_d;
            busy_q         <= busy_d;
            round_done_q   <= round_done_d;
            overrun_q      <= overrun_d;
            succ_q         <= succ_d;
            fail_q         <= fail_d;
            lazy_q         <= lazy_d;
        end
    end

    assign ev.eval_req    = eval_req_q;
    assign ev.eval_state  = eval_state_q;
    assign ev.eval_period = eval_period_q;
    assign busy           = busy_q;
    assign round_done     = round_done_q;
    assign live_cnt       = live_q;
    assign succ_cnt       = succ_q;
    assign fail_cnt       = fail_q;
    assign lazy_cnt       = lazy_q;
    assign tick_overrun   = overrun_q;
endmodule

// File: tb/tb_sva_thread_scheduler.sv
// Directed bench for sva_thread_scheduler with a behavioural evaluator whose
// transition table is selected per test and whose ack latency is programmable.
module tb_sva_thread_scheduler;
    import sva_sched_pkg::*;

    localparam int NS = 4;
    localparam int SW = 32;
    localparam int TW = 8;
    localparam int CW = 4;

    localparam int M_BASIC   = 0;  // 0->1 act, 1->2 act succ, 2 retires
    localparam int M_INC     = 1;  // s->s+1 act
    localparam int M_FAIL    = 2;  // retire with fail
    localparam int M_COMPACT = 3;  // 2 retires lazy, 0 retires, others s+1

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          gclk_tick = 1'b0;
    logic [TW-1:0] timer_in = '0;
    logic          busy, round_done, overflow, tick_overrun;
    logic [2:0]    live_cnt;
    logic [CW-1:0] succ_cnt, fail_cnt, lazy_cnt;

    sva_thread_scheduler_if #(.STATE_W(SW), .TIMER_WIDTH(TW)) ev();

    sva_thread_scheduler #(
        .NUM_SLOTS   (NS),
        .STATE_W     (SW),
        .TIMER_WIDTH (TW),
        .START_STATE (0),
        .CNT_W       (CW)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .gclk_tick    (gclk_tick),
        .timer_in     (timer_in),
        .ev           (ev),
        .busy         (busy),
        .round_done   (round_done),
        .live_cnt     (live_cnt),
        .succ_cnt     (succ_cnt),
        .fail_cnt     (fail_cnt),
        .lazy_cnt     (lazy_cnt),
        .overflow     (overflow),
        .tick_overrun (tick_overrun)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int passed = 0;

    int            mode = M_BASIC;
    int            wait_n = 0;
    int            wcnt = 0;
    int            unstable = 0;
    int            log_n = 0;
    logic [SW-1:0] log_st [16];
    logic [TW-1:0] log_per [16];
    int            log_len [16];
    logic [SW-1:0] first_st;
    logic [TW-1:0] first_per;

    // Evaluator: samples requests on the falling edge, acks after wait_n extra cycles.
    initial begin
        ev.eval_ack         = 1'b0;
        ev.eval_next_state  = '0;
        ev.eval_next_active = 1'b0;
        ev.eval_verdict     = VERDICT_NONE;
        forever begin
            @(negedge sys_clk);
            if (ev.eval_req !== 1'b1 || sys_rst === 1'b1) begin
                ev.eval_ack = 1'b0;
                wcnt        = 0;
            end else if (ev.eval_ack !== 1'b1) begin
                if (wcnt == 0) begin
                    first_st  = ev.eval_state;
                    first_per = ev.eval_period;
                end else if (ev.eval_state !== first_st || ev.eval_period !== first_per) begin
                    unstable++;
                end
                if (wcnt >= wait_n) begin
                    ev.eval_next_state  = '0;
                    ev.eval_next_active = 1'b0;
                    ev.eval_verdict     = VERDICT_NONE;
                    case (mode)
                        M_BASIC: begin
                            if (ev.eval_state == 0) begin
                                ev.eval_next_state = 1; ev.eval_next_active = 1'b1;
                            end else if (ev.eval_state == 1) begin
                                ev.eval_next_state = 2; ev.eval_next_active = 1'b1;
                                ev.eval_verdict = VERDICT_SUCC;
                            end
                        end
                        M_INC: begin
                            ev.eval_next_state = ev.eval_state + 1; ev.eval_next_active = 1'b1;
                        end
                        M_FAIL: ev.eval_verdict = VERDICT_FAIL;
                        default: begin
                            if (ev.eval_state == 2) ev.eval_verdict = VERDICT_LAZY;
                            else if (ev.eval_state != 0) begin
                                ev.eval_next_state = ev.eval_state + 1; ev.eval_next_active = 1'b1;
                            end
                        end
                    endcase
                    if (log_n < 16) begin
                        log_st[log_n]  = ev.eval_state;
                        log_per[log_n] = ev.eval_period;
                        log_len[log_n] = wcnt + 1;
                    end
                    log_n++;
                    ev.eval_ack = 1'b1;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    task automatic apply_reset();
        sys_rst   = 1'b1;
        gclk_tick = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
    endtask

    // One tick, then wait for round_done; cyc = cycles from tick to round_done (-1 on timeout).
    // Returns one cycle after round_done, when busy has dropped and live_cnt is updated.
    task automatic do_round(input logic [TW-1:0] p, output int cyc);
        log_n = 0;
        @(negedge sys_clk);
        gclk_tick = 1'b1;
        timer_in  = p;
        @(negedge sys_clk);
        gclk_tick = 1'b0;
        cyc = 1;
        while (round_done !== 1'b1 && cyc < 200) begin
            @(negedge sys_clk);
            cyc++;
        end
        if (cyc >= 200) cyc = -1;
        @(negedge sys_clk);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        checks++; if (round_done !== 1'b0) $display("FAIL reset_round_done: got %b want 0", round_done); else passed++;
        checks++; if (ev.eval_req !== 1'b0) $display("FAIL reset_eval_req: got %b want 0", ev.eval_req); else passed++;
        checks++; if (live_cnt !== 3'd0) $display("FAIL reset_live: got %0d want 0", live_cnt); else passed++;
        checks++; if ({succ_cnt, fail_cnt, lazy_cnt} !== '0)
            $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", succ_cnt, fail_cnt, lazy_cnt); else passed++;
        checks++; if ({overflow, tick_overrun} !== 2'b00)
            $display("FAIL reset_flags: got ovf=%b ovr=%b want 0 0", overflow, tick_overrun); else passed++;
    endtask

    task automatic test_first_round();
        int cyc;
        mode = M_BASIC; wait_n = 0;
        do_round(8'd5, cyc);
        checks++; if (cyc !== 3) $display("FAIL first_latency: got %0d want 3", cyc); else passed++;
        checks++; if (log_n !== 1 || log_st[0] !== 0 || log_per[0] !== 8'd5)
            $display("FAIL first_eval: got n=%0d st=%0d per=%0d want n=1 st=0 per=5", log_n, log_st[0], log_per[0]); else passed++;
        checks++; if (live_cnt !== 3'd1) $display("FAIL first_live: got %0d want 1", live_cnt); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL first_busy_drop: got %b want 0", busy); else passed++;
    endtask

    task automatic test_steady();
        int cyc;
        do_round(8'd9, cyc);
        checks++; if (cyc !== 5) $display("FAIL steady_latency_n1: got %0d want 5", cyc); else passed++;
        checks++; if (log_n !== 2 || log_st[0] !== 1 || log_per[0] !== 8'd5 || log_st[1] !== 0 || log_per[1] !== 8'd9)
            $display("FAIL steady_order_r2: got n=%0d (%0d,%0d)(%0d,%0d) want 2 (1,5)(0,9)",
                     log_n, log_st[0], log_per[0], log_st[1], log_per[1]); else passed++;
        checks++; if (live_cnt !== 3'd2 || succ_cnt !== 4'd1)
            $display("FAIL steady_r2: got live=%0d succ=%0d want 2 1", live_cnt, succ_cnt); else passed++;
        do_round(8'd13, cyc);
        checks++; if (cyc !== 7) $display("FAIL steady_latency_n2: got %0d want 7", cyc); else passed++;
        checks++; if (log_n !== 3 || log_st[0] !== 2 || log_per[0] !== 8'd5 || log_st[1] !== 1 ||
                      log_per[1] !== 8'd9 || log_st[2] !== 0 || log_per[2] !== 8'd13)
            $display("FAIL steady_order_r3: got n=%0d (%0d,%0d)(%0d,%0d)(%0d,%0d) want 3 (2,5)(1,9)(0,13)", log_n,
                     log_st[0], log_per[0], log_st[1], log_per[1], log_st[2], log_per[2]); else passed++;
        checks++; if (live_cnt !== 3'd2 || succ_cnt !== 4'd2)
            $display("FAIL steady_r3: got live=%0d succ=%0d want 2 2", live_cnt, succ_cnt); else passed++;
    endtask

    task automatic test_overflow();
        int cyc;
        apply_reset();
        mode = M_INC; wait_n = 0;
        for (int i = 1; i <= 4; i++) do_round(TW'(i), cyc);
        checks++; if (live_cnt !== 3'd4 || overflow !== 1'b0)
            $display("FAIL ovf_fill: got live=%0d ovf=%b want 4 0", live_cnt, overflow); else passed++;
        do_round(8'd5, cyc);
        checks++; if (cyc !== 11) $display("FAIL ovf_latency: got %0d want 11", cyc); else passed++;
        checks++; if (log_n !== 5 || log_st[0] !== 4 || log_per[0] !== 8'd1 || log_st[4] !== 0 || log_per[4] !== 8'd5)
            $display("FAIL ovf_evals: got n=%0d first(%0d,%0d) spawn(%0d,%0d) want 5 (4,1)(0,5)",
                     log_n, log_st[0], log_per[0], log_st[4], log_per[4]); else passed++;
        checks++; if (live_cnt !== 3'd4 || overflow !== 1'b1)
            $display("FAIL ovf_drop: got live=%0d ovf=%b want 4 1", live_cnt, overflow); else passed++;
    endtask

    task automatic test_wait_states();
        int cyc;
        apply_reset();
        mode = M_BASIC; wait_n = 3; unstable = 0;
        do_round(8'd5, cyc);
        checks++; if (cyc !== 6) $display("FAIL wait_latency_n0: got %0d want 6", cyc); else passed++;
        checks++; if (log_n !== 1 || log_len[0] !== 4 || log_st[0] !== 0 || log_per[0] !== 8'd5)
            $display("FAIL wait_req_hold: got n=%0d len=%0d st=%0d per=%0d want 1 4 0 5",
                     log_n, log_len[0], log_st[0], log_per[0]); else passed++;
        do_round(8'd9, cyc);
        checks++; if (cyc !== 11) $display("FAIL wait_latency_n1: got %0d want 11", cyc); else passed++;
        checks++; if (log_n !== 2 || log_st[0] !== 1 || log_per[0] !== 8'd5 || log_st[1] !== 0 || log_per[1] !== 8'd9)
            $display("FAIL wait_order: got n=%0d (%0d,%0d)(%0d,%0d) want 2 (1,5)(0,9)",
                     log_n, log_st[0], log_per[0], log_st[1], log_per[1]); else passed++;
        checks++; if (unstable !== 0) $display("FAIL wait_stable: got %0d changes want 0", unstable); else passed++;
        checks++; if (live_cnt !== 3'd2 || succ_cnt !== 4'd1)
            $display("FAIL wait_result: got live=%0d succ=%0d want 2 1", live_cnt, succ_cnt); else passed++;
    endtask

    task automatic test_overrun();
        int pulses = 0;
        wait_n = 0; log_n = 0;
        checks++; if (tick_overrun !== 1'b0) $display("FAIL overrun_pre: got %b want 0", tick_overrun); else passed++;
        @(negedge sys_clk); gclk_tick = 1'b1; timer_in = 8'd20;
        @(negedge sys_clk); gclk_tick = 1'b0;
        @(negedge sys_clk); gclk_tick = 1'b1; timer_in = 8'd21;
        @(negedge sys_clk); gclk_tick = 1'b0;
        repeat (20) begin
            @(negedge sys_clk);
            if (round_done === 1'b1) pulses++;
        end
        checks++; if (pulses !== 1) $display("FAIL overrun_rounds: got %0d want 1", pulses); else passed++;
        checks++; if (tick_overrun !== 1'b1) $display("FAIL overrun_flag: got %b want 1", tick_overrun); else passed++;
        checks++; if (live_cnt !== 3'd2 || succ_cnt !== 4'd2 || busy !== 1'b0)
            $display("FAIL overrun_state: got live=%0d succ=%0d busy=%b want 2 2 0", live_cnt, succ_cnt, busy); else passed++;
    endtask

    task automatic test_reset_mid_eval();
        int n = 0;
        wait_n = 3;
        @(negedge sys_clk); gclk_tick = 1'b1; timer_in = 8'd30;
        @(negedge sys_clk); gclk_tick = 1'b0;
        while (ev.eval_req !== 1'b1 && n < 10) begin
            @(negedge sys_clk);
            n++;
        end
        checks++; if (ev.eval_req !== 1'b1) $display("FAIL midrst_req_seen: got %b want 1", ev.eval_req); else passed++;
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        checks++; if (ev.eval_req !== 1'b0 || busy !== 1'b0)
            $display("FAIL midrst_idle: got req=%b busy=%b want 0 0", ev.eval_req, busy); else passed++;
        checks++; if (live_cnt !== 3'd0 || succ_cnt !== 4'd0 || tick_overrun !== 1'b0)
            $display("FAIL midrst_clear: got live=%0d succ=%0d ovr=%b want 0 0 0", live_cnt, succ_cnt, tick_overrun); else passed++;
        wait_n = 0;
    endtask

    task automatic test_saturate();
        int cyc;
        apply_reset();
        mode = M_FAIL; wait_n = 0;
        for (int i = 0; i < 15; i++) do_round(TW'(i), cyc);
        checks++; if (fail_cnt !== 4'hF) $display("FAIL sat_reach: got %0d want 15", fail_cnt); else passed++;
        do_round(8'd99, cyc);
        checks++; if (fail_cnt !== 4'hF) $display("FAIL sat_hold: got %0d want 15", fail_cnt); else passed++;
        checks++; if (live_cnt !== 3'd0 || succ_cnt !== 4'd0 || cyc !== 3)
            $display("FAIL sat_other: got live=%0d succ=%0d cyc=%0d want 0 0 3", live_cnt, succ_cnt, cyc); else passed++;
    endtask

    task automatic test_compaction();
        int cyc;
        apply_reset();
        mode = M_INC; wait_n = 0;
        for (int i = 1; i <= 3; i++) do_round(TW'(i), cyc);
        mode = M_COMPACT;
        do_round(8'd4, cyc);
        checks++; if (cyc !== 9) $display("FAIL compact_latency: got %0d want 9", cyc); else passed++;
        checks++; if (live_cnt !== 3'd2 || lazy_cnt !== 4'd1)
            $display("FAIL compact_live: got live=%0d lazy=%0d want 2 1", live_cnt, lazy_cnt); else passed++;
        mode = M_INC;
        do_round(8'd5, cyc);
        checks++; if (log_n !== 3 || log_st[0] !== 4 || log_per[0] !== 8'd1 || log_st[1] !== 2 ||
                      log_per[1] !== 8'd3 || log_st[2] !== 0 || log_per[2] !== 8'd5)
            $display("FAIL compact_order: got n=%0d (%0d,%0d)(%0d,%0d)(%0d,%0d) want 3 (4,1)(2,3)(0,5)", log_n,
                     log_st[0], log_per[0], log_st[1], log_per[1], log_st[2], log_per[2]); else passed++;
        checks++; if (live_cnt !== 3'd3) $display("FAIL compact_after: got %0d want 3", live_cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_first_round();
        test_steady();
        test_overflow();
        test_wait_states();
        test_overrun();
        test_reset_mid_eval();
        test_saturate();
        test_compaction();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, checks);
        $fatal(1);
    end
endmodule
